// File: rtl/grid_pkg.sv
// Shared grid playfield definitions: geometry defaults, cell encoding,
// line-clear state encoding and the line-clear score award table.
package grid_pkg;

    localparam int GRID_COLS_DEF  = 10;
    localparam int GRID_ROWS_DEF  = 20;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 8;

    localparam int CELL_EMPTY = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EVAL  = 3'd2,
        WRITE = 3'd3,
        FILL  = 3'd4,
        DONE  = 3'd5
    } lc_state_t;

    localparam logic [15:0] AWARD_1 = 16'd40;
    localparam logic [15:0] AWARD_2 = 16'd100;
    localparam logic [15:0] AWARD_3 = 16'd300;
    localparam logic [15:0] AWARD_4 = 16'd1200;

    function automatic logic [15:0] line_award(input logic [4:0] n);
        case (n)
            5'd1:    return AWARD_1;
            5'd2:    return AWARD_2;
            5'd3:    return AWARD_3;
            5'd4:    return AWARD_4;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/grid_row_addr.sv
// Combinational cell address generator: addr = row*GRID_COLS + col.
// Shared between the line-clear engine and the renderer.
module grid_row_addr #(
    parameter int ADDR_WIDTH = 8,
    parameter int GRID_COLS  = 10,
    parameter int ROW_W      = 6,
    parameter int COL_W      = 4
) (
    input  logic [ROW_W-1:0]      row,
    input  logic [COL_W-1:0]      col,
    output logic [ADDR_WIDTH-1:0] addr
);

    assign addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(GRID_COLS) + ADDR_WIDTH'(col);

endmodule

// File: rtl/grid_line_clear.sv
// Tetris line-clear engine: scans the grid bottom-up, compacts surviving rows
// and zero-fills the top. Optional score output under macro GRID_LC_SCORE_EN.
import grid_pkg::*;

module grid_line_clear #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int GRID_COLS  = GRID_COLS_DEF,
    parameter int GRID_ROWS  = GRID_ROWS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            lines_cleared,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef GRID_LC_SCORE_EN
    ,
    output logic [15:0]           score
`endif
);

    localparam int ROW_W = $clog2(GRID_ROWS) + 1;
    localparam int COL_W = $clog2(GRID_COLS + 1);

    lc_state_t                state_r, state_n;
    logic [COL_W-1:0]         col_r, col_n;
    logic signed [ROW_W-1:0]  src_r, src_n, dst_r, dst_n;
    logic [DATA_WIDTH-1:0]    row_buf_r [GRID_COLS];
    logic                     full_r, full_n;
    logic [4:0]               lines_r, lines_n;
    logic                     busy_r, done_r;
    logic [4:0]               lines_cleared_r;
    logic                     act_s, we_s, cap_s, exit_s;
    logic [ROW_W-1:0]         row_sel_s;
    logic [DATA_WIDTH-1:0]    wdata_s;
    logic [ADDR_WIDTH-1:0]    addr_s;

    grid_row_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .GRID_COLS  (GRID_COLS),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_addr (
        .row  (row_sel_s),
        .col  (col_r),
        .addr (addr_s)
    );

    // Next-state, counter updates and port A drive
    always_comb begin
        state_n   = state_r;
        col_n     = col_r;
        src_n     = src_r;
        dst_n     = dst_r;
        full_n    = full_r;
        lines_n   = lines_r;
        act_s     = 1'b0;
        we_s      = 1'b0;
        cap_s     = 1'b0;
        exit_s    = 1'b0;
        row_sel_s = src_r;
        wdata_s   = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n = READ;
                    col_n   = {COL_W{1'b0}};
                    src_n   = ROW_W'(GRID_ROWS - 1);
                    dst_n   = ROW_W'(GRID_ROWS - 1);
                    lines_n = 5'd0;
                    full_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            READ: begin
                act_s = (col_r < COL_W'(GRID_COLS));
                if (col_r != {COL_W{1'b0}}) begin
                    cap_s  = 1'b1;
                    full_n = full_r & (mem_rdata != DATA_WIDTH'(CELL_EMPTY));
                end else begin
                    cap_s = 1'b0;
                end
                if (col_r == COL_W'(GRID_COLS)) begin
                    state_n = EVAL;
                    col_n   = {COL_W{1'b0}};
                end else begin
                    col_n = col_r + COL_W'(1);
                end
            end
            EVAL: begin
                src_n = src_r - ROW_W'(1);
                if (full_r) begin
                    lines_n = lines_r + 5'd1;
                    exit_s  = 1'b1;
                end else if (src_r != dst_r) begin
                    state_n = WRITE;
                    col_n   = {COL_W{1'b0}};
                end else begin
                    dst_n  = dst_r - ROW_W'(1);
                    exit_s = 1'b1;
                end
            end
            WRITE: begin
                act_s     = 1'b1;
                we_s      = 1'b1;
                row_sel_s = dst_r;
                wdata_s   = row_buf_r[col_r];
                if (col_r == COL_W'(GRID_COLS - 1)) begin
                    dst_n  = dst_r - ROW_W'(1);
                    exit_s = 1'b1;
                end else begin
                    col_n = col_r + COL_W'(1);
                end
            end
            FILL: begin
                act_s     = 1'b1;
                we_s      = 1'b1;
                row_sel_s = dst_r;
                if (col_r == COL_W'(GRID_COLS - 1)) begin
                    dst_n = dst_r - ROW_W'(1);
                    col_n = {COL_W{1'b0}};
                    if (dst_n[ROW_W-1]) begin
                        state_n = DONE;
                    end else begin
                        state_n = FILL;
                    end
                end else begin
                    col_n = col_r + COL_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Shared exit after a row is retired: more rows to scan, fill, or finish
        if (exit_s) begin
            col_n  = {COL_W{1'b0}};
            full_n = 1'b1;
            if (!src_n[ROW_W-1]) begin
                state_n = READ;
            end else if (dst_n[ROW_W-1] || (lines_n == 5'd0)) begin
                state_n = DONE;
            end else begin
                state_n = FILL;
            end
        end else begin
            full_n = full_n;
        end
    end

    // State, counters, row buffer and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            col_r           <= {COL_W{1'b0}};
            src_r           <= {ROW_W{1'b0}};
            dst_r           <= {ROW_W{1'b0}};
            full_r          <= 1'b0;
            lines_r         <= 5'd0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            lines_cleared_r <= 5'd0;
            for (int i = 0; i < GRID_COLS; i++) begin
                row_buf_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_r <= state_n;
            col_r   <= col_n;
            src_r   <= src_n;
            dst_r   <= dst_n;
            full_r  <= full_n;
            lines_r <= lines_n;
            busy_r  <= (state_n != IDLE) && (state_n != DONE);
            done_r  <= (state_n == DONE);
            if (state_n == DONE) begin
                lines_cleared_r <= lines_n;
            end else begin
                lines_cleared_r <= lines_cleared_r;
            end
            if (cap_s) begin
                row_buf_r[col_r - COL_W'(1)] <= mem_rdata;
            end else begin
                row_buf_r <= row_buf_r;
            end
        end
    end

`ifdef GRID_LC_SCORE_EN
    logic [15:0] score_r;
    logic [16:0] score_sum_s;

    assign score_sum_s = {1'b0, score_r} + {1'b0, line_award(lines_n)};

    // Saturating score accumulator, credited as the pass finishes
    always_ff @(posedge clk) begin
        if (reset) begin
            score_r <= 16'd0;
        end else if (state_n == DONE) begin
            score_r <= score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        end else begin
            score_r <= score_r;
        end
    end

    assign score = score_r;
`endif

    assign busy          = busy_r;
    assign done          = done_r;
    assign lines_cleared = lines_cleared_r;
    assign mem_we        = we_s;
    assign mem_wdata     = wdata_s;
    assign mem_addr      = act_s ? addr_s : {ADDR_WIDTH{1'b0}};

endmodule
